// File: rtl/pick_fifo_pkg.sv
// Shared definitions for the multi-flux FIFO read scheduler: tag width,
// scheduler state encoding and weight extraction from the flattened config bus.
package pick_fifo_pkg;

  localparam int FLUX_DEFAULT = 2;
  localparam int TAG_WIDTH    = $clog2(FLUX_DEFAULT);
  localparam int CFG_MAX_W    = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } sched_state_t;

  // Weight idx of a bus packed as wbits-wide fields; the caller zero-extends to CFG_MAX_W.
  function automatic logic [15:0] weight_at(input logic [CFG_MAX_W-1:0] flat,
                                            input int idx, input int wbits);
    logic [CFG_MAX_W-1:0] sh;
    logic [CFG_MAX_W-1:0] mask;
    sh   = flat >> (idx * wbits);
    mask = (CFG_MAX_W'(1) << wbits) - CFG_MAX_W'(1);
    return 16'(sh & mask);
  endfunction

endpackage

// File: rtl/pick_fifo_rd_sched_rr_next_sel.sv
// Combinational circular first-set search over req, starting at start.
// REVERSE walks downward (start, start-1, ...) instead of upward.
module rr_next_sel #(
  parameter int N       = 2,
  parameter int IW      = 1,
  parameter bit REVERSE = 1'b0
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found) begin
        j = REVERSE ? ((int'(start) - k + N) % N) : ((int'(start) + k) % N);
        if (req[j]) begin
          found = 1'b1;
          idx   = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pick_fifo_rd_sched.sv
// Read-side scheduler for the multi-flux tagged FIFO: picks the flux to pop
// (weighted round-robin or strict priority) and registers the word downstream.
module pick_fifo_rd_sched
  import pick_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FLUX     = 2,
  parameter int WEIGHT_W = 4
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cfg_prio,
  input  logic [FLUX*WEIGHT_W-1:0]   cfg_weight,
  input  logic [FLUX-1:0]            fifo_empty,
  input  logic [WIDTH-1:0]           fifo_data,
  output logic [FLUX-1:0]            fifo_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(FLUX)-1:0]    out_flux,
  output logic [$clog2(FLUX)-1:0]    cur_flux
);

  localparam int TW = $clog2(FLUX);

  // Handshake: a word moves downstream on any cycle with out_valid & out_ready;
  // out_valid and out_data never change while out_valid & ~out_ready.

  sched_state_t          state;
  logic [WEIGHT_W-1:0]   credit [FLUX];
  logic [WEIGHT_W-1:0]   wt_eff [FLUX];
  logic [WEIGHT_W-1:0]   w_tmp;

  logic [FLUX-1:0]       req;
  logic                  can_pop;
  logic                  pop;
  logic                  serve_hit;
  logic [TW-1:0]         cur_next;
  logic [TW-1:0]         wrr_start;
  logic [TW-1:0]         wrr_idx;
  logic                  wrr_found;
  logic [TW-1:0]         prio_idx;
  logic                  prio_found;
  logic [TW-1:0]         grant;

  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] x);
    return (x == TW'(FLUX - 1)) ? '0 : x + TW'(1);
  endfunction

  // A programmed weight of 0 behaves like 1.
  always_comb begin
    w_tmp = '0;
    for (int i = 0; i < FLUX; i++) begin
      w_tmp     = WEIGHT_W'(weight_at(CFG_MAX_W'(cfg_weight), i, WEIGHT_W));
      wt_eff[i] = (w_tmp == '0) ? WEIGHT_W'(1) : w_tmp;
    end
  end

  assign req       = ~fifo_empty;
  assign can_pop   = en & (~out_valid | out_ready) & ~(&fifo_empty);
  assign serve_hit = (state == ST_SERVE) & req[cur_flux];
  assign cur_next  = wrap_inc(cur_flux);
  // SERVE only searches when the served flux ran dry, so start past it.
  assign wrr_start = (state == ST_SERVE) ? cur_next : cur_flux;

  rr_next_sel #(.N(FLUX), .IW(TW), .REVERSE(1'b0)) u_wrr_sel (
    .req   (req),
    .start (wrr_start),
    .idx   (wrr_idx),
    .found (wrr_found)
  );

  rr_next_sel #(.N(FLUX), .IW(TW), .REVERSE(1'b1)) u_prio_sel (
    .req   (req),
    .start (TW'(FLUX - 1)),
    .idx   (prio_idx),
    .found (prio_found)
  );

  assign grant   = cfg_prio ? prio_idx : (serve_hit ? cur_flux : wrr_idx);
  assign pop     = can_pop & (cfg_prio ? prio_found : (serve_hit | wrr_found));
  assign fifo_rd = pop ? (FLUX'(1) << grant) : '0;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_flux  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flux  <= '0;
      for (int i = 0; i < FLUX; i++) credit[i] <= '0;
    end else begin
      if (pop) begin
        out_data  <= fifo_data;
        out_flux  <= grant;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (pop && !cfg_prio) begin
        if (serve_hit) begin
          credit[cur_flux] <= credit[cur_flux] - WEIGHT_W'(1);
          if (credit[cur_flux] == WEIGHT_W'(1)) begin
            cur_flux <= cur_next;
            state    <= ST_IDLE;
          end
        end else begin
          // Served flux went empty with credit left: drop it and move on this cycle.
          if (state == ST_SERVE) credit[cur_flux] <= '0;
          credit[wrr_idx] <= wt_eff[wrr_idx] - WEIGHT_W'(1);
          if (wt_eff[wrr_idx] > WEIGHT_W'(1)) begin
            cur_flux <= wrr_idx;
            state    <= ST_SERVE;
          end else begin
            cur_flux <= wrap_inc(wrr_idx);
            state    <= ST_IDLE;
          end
        end
      end
    end
  end

  a_no_empty_pop: assert property (@(posedge ck) disable iff (rst)
    (fifo_rd & fifo_empty) == '0);

endmodule

// File: tb/tb_pick_fifo_rd_sched.sv
// Bench for pick_fifo_rd_sched (FLUX=4): per-flux FIFO model, visit-level
// scheduling model that precomputes the pop order, and an output scoreboard.
module tb_pick_fifo_rd_sched;

  logic        ck = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_prio;
  logic [15:0] cfg_weight;
  logic [3:0]  fifo_empty;
  logic [7:0]  fifo_data;
  logic [3:0]  fifo_rd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_flux;
  logic [1:0]  cur_flux;
  logic        load_en;

  int cnt [4];
  int popped [4];
  int load_cnt [4];

  int         pop_q [$];
  logic [7:0] exp_q [$];
  logic [3:0] obs_log [$];
  int         cyc_log [$];
  int         exp_seq [4];
  logic       exp_ov;
  int         m_p, m_left;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;

  pick_fifo_rd_sched #(.WIDTH(8), .FLUX(4), .WEIGHT_W(4)) dut (
    .ck         (ck),
    .rst        (rst),
    .en         (en),
    .cfg_prio   (cfg_prio),
    .cfg_weight (cfg_weight),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flux   (out_flux),
    .cur_flux   (cur_flux)
  );

  // clock / reset
  always #5 ck = ~ck;

  // FIFO model: word k of flux f is {f, k}, presented in the cycle it is popped.
  always @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < 4; f++) begin
        cnt[f]    <= 0;
        popped[f] <= 0;
      end
    end else begin
      for (int f = 0; f < 4; f++) begin
        if (load_en) cnt[f] <= load_cnt[f];
        else if (fifo_rd[f]) begin
          cnt[f]    <= cnt[f] - 1;
          popped[f] <= popped[f] + 1;
        end
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int f = 0; f < 4; f++) begin
      fifo_empty[f] = (cnt[f] == 0);
      if (fifo_rd[f]) fifo_data = {2'(f), 6'(popped[f])};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int wt(input int n);
    int v;
    v = int'((cfg_weight >> (4 * n)) & 16'h000f);
    return (v == 0) ? 1 : v;
  endfunction

  // Visit-level model: a visit to flux n takes min(credit, words left) pops.
  task automatic plan();
    int rem [4];
    int n, budget, take, start;
    for (int f = 0; f < 4; f++) rem[f] = load_cnt[f];
    if (cfg_prio) begin
      for (int f = 3; f >= 0; f--) repeat (rem[f]) pop_q.push_back(f);
    end else begin
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
        if (m_left > 0 && rem[m_p] > 0) begin
          n = m_p;
          budget = m_left;
        end else begin
          start = (m_left > 0) ? (m_p + 1) % 4 : m_p;
          n = start;
          while (rem[n] == 0) n = (n + 1) % 4;
          budget = wt(n);
        end
        take = (budget < rem[n]) ? budget : rem[n];
        repeat (take) pop_q.push_back(n);
        rem[n] -= take;
        if (budget == take) begin
          m_p = (n + 1) % 4;
          m_left = 0;
        end else begin
          m_p = n;
          m_left = budget - take;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check after settling, update the scoreboard at posedge.
  task automatic step(input logic en_v, input logic rdy_v);
    logic       exp_can;
    logic       xfer;
    logic [3:0] exp_rd;
    logic [7:0] head;
    int         g;
    en        = en_v;
    out_ready = rdy_v;
    #1;
    exp_can = en_v && (!exp_ov || rdy_v) && (pop_q.size() > 0);
    exp_rd  = '0;
    g       = 0;
    if (exp_can) begin
      g = pop_q.pop_front();
      exp_rd = 4'(1 << g);
    end
    check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
    check("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov && exp_q.size() > 0) begin
      head = exp_q[0];
      check("out_data", 32'(out_data), 32'(head));
      check("out_flux", 32'(out_flux), 32'(head[7:6]));
    end
    if (fifo_rd != 0) begin
      obs_log.push_back(fifo_rd);
      cyc_log.push_back(cyc);
    end
    if (exp_can) begin
      exp_q.push_back({2'(g), 6'(exp_seq[g])});
      exp_seq[g]++;
    end
    xfer = exp_ov && rdy_v;
    @(posedge ck);
    if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
    exp_ov = exp_can ? 1'b1 : (xfer ? 1'b0 : exp_ov);
    cyc++;
    @(negedge ck);
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    load_cnt[0] = c0;
    load_cnt[1] = c1;
    load_cnt[2] = c2;
    load_cnt[3] = c3;
    load_en = 1'b1;
    step(1'b0, 1'b1);
    load_en = 1'b0;
    plan();
  endtask

  task automatic run(input bit rnd, input int budget);
    int n = 0;
    while ((pop_q.size() > 0 || exp_ov) && n < budget) begin
      if (rnd) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      else step(1'b1, 1'b1);
      n++;
    end
    check("drain_timeout", 32'(pop_q.size() == 0 && !exp_ov), 32'd1);
    check("cur_flux", 32'(cur_flux), 32'(m_p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    load_en = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    pop_q.delete();
    exp_q.delete();
    obs_log.delete();
    cyc_log.delete();
    for (int f = 0; f < 4; f++) exp_seq[f] = 0;
    exp_ov = 1'b0;
    m_p = 0;
    m_left = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flux", 32'(out_flux), 32'd0);
    check("rst_cur_flux", 32'(cur_flux), 32'd0);
    @(negedge ck);
  endtask

  initial begin
    logic [3:0] tbl [8];
    int         t0;
    tbl = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    load_en = 1'b0;
    cfg_prio = 1'b0;
    cfg_weight = 16'h1111;
    exp_ov = 1'b0;
    m_p = 0;
    m_left = 0;

    // reset / idle with everything empty
    do_reset();
    repeat (20) step(1'b1, 1'b1);

    // WRR ratio w0=1, w1=3
    do_reset();
    cfg_weight = 16'h1131;
    load(8, 8, 0, 0);
    run(1'b0, 200);
    for (int i = 0; i < 8; i++)
      if (i < obs_log.size()) check("wrr_pattern", 32'(obs_log[i]), 32'(tbl[i]));

    // forfeit: w0=4 but flux0 has only 2 words
    do_reset();
    cfg_weight = 16'h1114;
    load(2, 5, 0, 0);
    run(1'b0, 200);
    if (obs_log.size() >= 3) begin
      check("forfeit_switch", 32'(obs_log[2]), 32'h2);
      check("forfeit_no_bubble", 32'(cyc_log[2] - cyc_log[1]), 32'd1);
    end

    // backpressure: stall 5 cycles after the first word
    do_reset();
    cfg_weight = 16'h1111;
    load(3, 2, 0, 0);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    t0 = cyc;
    step(1'b1, 1'b1);
    if (cyc_log.size() >= 2) check("resume_same_cycle", 32'(cyc_log[1]), 32'(t0));
    run(1'b0, 200);

    // strict priority, fluxes 1 and 3
    do_reset();
    cfg_prio = 1'b1;
    load(0, 3, 0, 2);
    run(1'b0, 200);
    if (obs_log.size() >= 3) begin
      check("prio_first", 32'(obs_log[0]), 32'h8);
      check("prio_after", 32'(obs_log[2]), 32'h2);
    end
    cfg_prio = 1'b0;

    // wrap from cur_flux=3, then en drop during traffic
    do_reset();
    cfg_weight = 16'h1111;
    load(0, 0, 1, 0);
    run(1'b0, 100);
    load(2, 0, 0, 0);
    run(1'b0, 100);
    load(3, 3, 0, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("en_drop_drained", 32'(out_valid), 32'd0);
    run(1'b0, 100);

    // randomized traffic, weights (including 0) and policy
    do_reset();
    for (int it = 0; it < 40; it++) begin
      cfg_weight = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                    4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
      cfg_prio = ($urandom_range(0, 3) == 0);
      load($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      run(1'b1, 600);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
